exec_ctrl: RTL
==============

# exec_ctrl

Multi-cycle sequencer for the 17-bit three-address datapath. It fetches each instruction from instruction memory and splits it into alu_sig/oper1/oper2/dest. It then reads both operands from the single-port 32x32 data memory, drives the external ALU, and writes the result back to dest. It sits above the decode stage and owns every memory and ALU control strobe; software starts it with a one-cycle `start` and observes `busy`/`done`.

## Interface
- INST_LEN, 17, instruction width: alu_sig[16:15], oper1[14:10], oper2[9:5], dest[4:0]
- WORD_SIZE, 32, data word width
- MEM_SIZE, 32, data memory depth
- ADDR_LEN, 5, data memory address width
- PC_LEN, 5, instruction memory address width
- Reset: one clock, synchronous, active-high.
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; start program at pc 0
- last_pc  in  PC_LEN  address of final instruction; sampled on accepted start
- halt_req  in  1  level; stop after current instruction's write-back
- imem_addr  out  PC_LEN  instruction address
- inst  in  INST_LEN  instruction, valid one cycle after imem_addr
- mem_addr  out  ADDR_LEN  data memory address
- mem_rd  out  1  data read strobe; mem_rdata valid next cycle
- mem_wr  out  1  data write strobe
- mem_wdata  out  WORD_SIZE  write data
- mem_rdata  in  WORD_SIZE  read data
- alu_sig  out  2  ALU opcode, held from latched instruction
- alu_a, alu_b  out  WORD_SIZE  latched operands
- alu_res  in  WORD_SIZE  combinational ALU result
- pc  out  PC_LEN  current instruction address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on return to IDLE after a run

## Operation
- States: IDLE, FETCH, DECODE, RD1, RD2, EXEC, WB.
- IDLE: start=1 -> FETCH; pc<=0, end_pc<=last_pc.
- FETCH: imem_addr=pc -> DECODE.
- DECODE: ir<=inst -> RD1.
- RD1: mem_rd=1, mem_addr=ir oper1 -> RD2.
- RD2: mem_rd=1, mem_addr=ir oper2; a<=mem_rdata -> EXEC.
- EXEC: b<=mem_rdata -> WB.
- WB: mem_wr=1, mem_addr=ir dest, mem_wdata=alu_res.
  - pc==end_pc or halt_req=1: -> IDLE, done=1 next cycle.
  - Otherwise: pc<=pc+1 -> FETCH.
- Moore outputs: strobes, addresses and done decode from state and registers only; no input-to-output combinational path except mem_wdata=alu_res.
- start outside IDLE is ignored; last_pc changes after start have no effect.
- halt_req is sampled only in WB; halt raised earlier lets the current instruction complete.
- pc never wraps: end_pc=31 terminates after instruction 31.
- dest equal to oper1/oper2 is legal; operands are latched before WB.
- Data memory is not written or read outside WB/RD1/RD2.

## Timing
- Reset (next edge): state=IDLE, pc=0, ir=0, a=b=0.
  - Outputs: busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, imem_addr=0, alu_sig=0.
- Reset mid-run aborts at once; a pending WB is not performed.
- Instruction latency: 6 cycles FETCH..WB; N instructions = 6N cycles of busy; done 1 cycle after last WB.
- Read-after-write: the next instruction's RD1 is 3 cycles after WB; no forwarding required.

## Structure
- Package exec_pkg:
  - state enum;
  - field-slice constants (ALU_HI=16, ALU_LO=15, OP1_HI=14, OP2_HI=9, DST_HI=4);
  - ALU opcodes, bench model: ADD=00, SUB=01, AND=10, OR=11.
- Sub-module inst_fields: combinational split of ir into alu_sig/oper1/oper2/dest, shared with the decode stage.
- FSM, pc and operand registers stay in exec_ctrl.

## Test plan
- Single ADD: M[1]=5, M[2]=7, inst {00,1,2,3}, last_pc=0, start -> M[3]=12, done pulse 6 cycles after FETCH, busy 6 cycles.
- Three-instruction program, SUB then OR with dest reused as oper1 of the next instruction -> correct chained values, 18 busy cycles, pc ends 2.
- halt_req raised during RD2 of instruction 1 of a 4-instruction program -> instruction 1 written, instruction 2 never fetched, done pulse.
- start pulsed while busy, and last_pc changed mid-run -> ignored, run ends at the originally sampled last_pc.
- rst asserted in EXEC -> next cycle: IDLE, mem_wr never asserted, dest word unchanged, all outputs at reset values.
- last_pc=31, 32 AND instructions -> all 32 write-backs, no pc wrap, single done.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and field layout for the three-address execution sequencer.
// Imported by the sequencer and by the decode stage.
package exec_pkg;

    localparam int INST_LEN  = 17;
    localparam int WORD_SIZE = 32;
    localparam int MEM_SIZE  = 32;
    localparam int ADDR_LEN  = 5;
    localparam int PC_LEN    = 5;

    localparam int ALU_HI = 16;
    localparam int ALU_LO = 15;
    localparam int OP1_HI = 14;
    localparam int OP2_HI = 9;
    localparam int DST_HI = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RD1,
        S_RD2,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/inst_fields.sv
// Combinational split of a latched instruction word into its fields.
// Shared with the decode stage so both agree on the bit layout.
module inst_fields
    import exec_pkg::*;
(
    input  logic [INST_LEN-1:0] ir,
    output logic [1:0]          alu_sig,
    output logic [ADDR_LEN-1:0] oper1,
    output logic [ADDR_LEN-1:0] oper2,
    output logic [ADDR_LEN-1:0] dest
);

    assign alu_sig = ir[ALU_HI:ALU_LO];
    assign oper1   = ir[OP1_HI -: ADDR_LEN];
    assign oper2   = ir[OP2_HI -: ADDR_LEN];
    assign dest    = ir[DST_HI -: ADDR_LEN];

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle sequencer: fetch, read two operands, drive the ALU, write back.
// Owns every data-memory and ALU strobe; software sees busy/done.
module exec_ctrl
    import exec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_LEN-1:0]    last_pc,
    input  logic                 halt_req,
    output logic [PC_LEN-1:0]    imem_addr,
    input  logic [INST_LEN-1:0]  inst,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [1:0]           alu_sig,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_res,
    output logic [PC_LEN-1:0]    pc,
    output logic                 busy,
    output logic                 done
);

    state_t                state;
    state_t                state_nx;
    logic [PC_LEN-1:0]     end_pc;
    logic [INST_LEN-1:0]   ir;
    logic [WORD_SIZE-1:0]  a;
    logic [WORD_SIZE-1:0]  b;
    logic [ADDR_LEN-1:0]   oper1;
    logic [ADDR_LEN-1:0]   oper2;
    logic [ADDR_LEN-1:0]   dest;
    logic                  fin;

    inst_fields u_fields (
        .ir      (ir),
        .alu_sig (alu_sig),
        .oper1   (oper1),
        .oper2   (oper2),
        .dest    (dest)
    );

    // halt_req only matters once the current write-back is under way
    assign fin = (state == S_WB) && ((pc == end_pc) || halt_req);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_RD1;
            S_RD1:    state_nx = S_RD2;
            S_RD2:    state_nx = S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = fin ? S_IDLE : S_FETCH;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            end_pc <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fin;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc     <= '0;
                        end_pc <= last_pc;
                    end
                end
                S_DECODE: ir <= inst;
                S_RD2:    a  <= mem_rdata;
                S_EXEC:   b  <= mem_rdata;
                S_WB:     if (!fin) pc <= pc + 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        unique case (state)
            S_RD1: begin
                mem_rd   = 1'b1;
                mem_addr = oper1;
            end
            S_RD2: begin
                mem_rd   = 1'b1;
                mem_addr = oper2;
            end
            S_WB: begin
                mem_wr   = 1'b1;
                mem_addr = dest;
            end
            default: ;
        endcase
    end

    assign imem_addr = pc;
    assign mem_wdata = alu_res;
    assign alu_a     = a;
    assign alu_b     = b;
    assign busy      = (state != S_IDLE);

endmodule
